// File: rtl/heichips25_nibble_mem_bridge.sv
// Nibble-serial request/response bridge onto a 32-bit word memory port.
// Writes gather 8 nibbles plus strobes; reads return the word as 8 nibbles, LSB first.
module heichips25_nibble_mem_bridge #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_nibble_i,
    input  logic              req_strb_i,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [3:0]        rsp_nibble_o,
    output logic              rsp_last_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              err_strb_o
);

    typedef enum logic [2:0] {
        IDLE,
        WCOLLECT,
        MEMWR,
        MEMRD,
        RDWAIT,
        RSEND,
        COMMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       shift_q;
    logic [7:0]        strb_q;
    logic [2:0]        cnt_q;
    logic              err_q;
    logic              ready_en;
    logic [3:0]        be_w;
    logic              beat;

    assign beat        = req_valid_i & req_ready_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state != IDLE);
    assign err_strb_o  = err_q;

    // Byte enable i follows the low-nibble strobe of byte i.
    always_comb begin
        be_w = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            be_w[i] = strb_q[2*i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_nibble_o = '0;
        rsp_last_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        case (state)
            IDLE: begin
                req_ready_o = ready_en;
                if (req_valid_i && ready_en) begin
                    state_nxt = req_write_i ? WCOLLECT : MEMRD;
                end
            end
            WCOLLECT: begin
                req_ready_o = ready_en;
                if (req_valid_i && ready_en && cnt_q == 3'd7) begin
                    state_nxt = MEMWR;
                end
            end
            MEMWR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_be_o  = be_w;
                if (mem_gnt_i) begin
                    state_nxt = IDLE;
                end
            end
            MEMRD: begin
                mem_req_o = 1'b1;
                mem_be_o  = '1;
                if (mem_gnt_i) begin
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                state_nxt = RSEND;
            end
            RSEND: begin
                rsp_valid_o  = 1'b1;
                rsp_nibble_o = shift_q[3:0];
                rsp_last_o   = (cnt_q == 3'd7);
                if (rsp_ready_i && cnt_q == 3'd7) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                rsp_valid_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
            strb_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (beat) begin
                        addr_q <= req_addr_i;
                        if (req_write_i) begin
                            wdata_q <= {28'd0, req_nibble_i};
                            strb_q  <= {7'd0, req_strb_i};
                            cnt_q   <= 3'd1;
                        end
                    end
                end
                WCOLLECT: begin
                    if (beat) begin
                        wdata_q[{cnt_q, 2'b00} +: 4] <= req_nibble_i;
                        strb_q[cnt_q]                <= req_strb_i;
                        // Odd beat closes a byte: both strobes of it must agree.
                        if (cnt_q[0] && (req_strb_i != strb_q[cnt_q - 3'd1])) begin
                            err_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RDWAIT: begin
                    shift_q <= mem_rdata_i;
                    cnt_q   <= '0;
                end
                RSEND: begin
                    if (rsp_ready_i) begin
                        shift_q <= {4'd0, shift_q[31:4]};
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heichips25_nibble_mem_bridge.sv
// Self-checking bench: directed vector table, reset corner cases and randomized
// transactions against a word-level memory and nibble-stream reference model.
module tb_heichips25_nibble_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_nibble_i = '0;
    logic        req_strb_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [7:0]  req_addr_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  rsp_nibble_o;
    logic        rsp_last_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o;
    logic        err_strb_o;

    heichips25_nibble_mem_bridge #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_nibble_i (req_nibble_i),
        .req_strb_i   (req_strb_i),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .rsp_nibble_o (rsp_nibble_o),
        .rsp_last_o   (rsp_last_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .err_strb_o   (err_strb_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    // Memory side model: grants after gnt_delay cycles of request, read data the cycle after.
    logic [31:0] rmem [256];
    acc_t        acc_log [1024];
    int          acc_wr = 0;
    int          mreq_cnt = 0;
    int          hold_errs = 0;
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    logic        rd_pending = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        held_valid = 1'b0;
    logic [44:0] held = '0;

    always @(negedge clk) begin
        mem_rdata_i <= rd_pending ? rmem[rd_addr] : $urandom;
        rd_pending  <= 1'b0;
        if (!rst_n || !mem_req_o) begin
            mem_gnt_i  <= 1'b0;
            wait_cnt   <= 0;
            held_valid <= 1'b0;
        end else begin
            mreq_cnt <= mreq_cnt + 1;
            if (held_valid && ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== held)) begin
                hold_errs <= hold_errs + 1;
            end
            if (wait_cnt >= gnt_delay) begin
                mem_gnt_i       <= 1'b1;
                acc_log[acc_wr] <= {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
                acc_wr          <= acc_wr + 1;
                if (!mem_we_o) begin
                    rd_pending <= 1'b1;
                    rd_addr    <= mem_addr_o;
                end
                wait_cnt   <= 0;
                held_valid <= 1'b0;
            end else begin
                mem_gnt_i  <= 1'b0;
                wait_cnt   <= wait_cnt + 1;
                held_valid <= 1'b1;
                held       <= {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
            end
        end
    end

    int   n_checks = 0;
    int   n_fail = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [7:0] s);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = s[2*i];
        return be;
    endfunction

    function automatic logic model_mis(input logic [7:0] s);
        return (s & 8'h55) != ((s >> 1) & 8'h55);
    endfunction

    task automatic send_beat(input logic [3:0] nib, input logic s, input logic w, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_nibble_i = nib;
        req_strb_i   = s;
        req_write_i  = w;
        req_addr_i   = a;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready timeout: got 0 expected 1 (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] nibs, input logic [7:0] strb,
                            input int gd, input logic perturb, input int max_gap,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_err);
        int   start;
        int   n;
        logic w;
        logic [7:0] aa;
        acc_t r;
        gnt_delay = gd;
        start = acc_wr;
        for (int k = 0; k < 8; k++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
            w  = (k == 0 || !perturb) ? 1'b1 : 1'($urandom);
            aa = (k == 0 || !perturb) ? a : 8'($urandom);
            send_beat(nibs[4*k +: 4], strb[k], w, aa);
        end
        @(negedge clk);
        #1;
        check("ready low in mem write", 64'(req_ready_o), 64'd0);
        check("busy in mem write", 64'(busy_o), 64'd1);
        n = 0;
        while (acc_wr == start && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("write access count", 64'(acc_wr - start), 64'd1);
        if (acc_wr > start) begin
            r = acc_log[start];
            check("write we", 64'(r.we), 64'd1);
            check("write addr", 64'(r.addr), 64'(a));
            check("write be", 64'(r.be), 64'(exp_be));
            check("write wdata", 64'(r.wdata), 64'(exp_wdata));
        end
        @(posedge clk);
        #1;
        check("busy after write", 64'(busy_o), 64'd0);
        check("no rsp for write", 64'(rsp_valid_o), 64'd0);
        check("err_strb after write", 64'(err_strb_o), 64'(exp_err));
    endtask

    task automatic do_read(input logic [7:0] a, input int gd, input int rmode,
                           input logic [31:0] exp_seq, input int abort_at);
        int   start;
        int   got;
        int   cyc;
        int   v;
        logic seen;
        acc_t r;
        gnt_delay = gd;
        start = acc_wr;
        got = 0;
        cyc = 0;
        seen = 1'b0;
        send_beat(4'($urandom), 1'($urandom), 1'b0, a);
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            rsp_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom);
            #1;
            cyc++;
            if (rsp_valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("read latency", 64'(cyc), 64'(3 + gd));
                end
                check("rsp nibble", 64'(rsp_nibble_o), 64'(exp_seq[4*got +: 4]));
                check("rsp last", 64'(rsp_last_o), 64'(got == 7));
                if (rsp_ready_i) got++;
                if (got == abort_at) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("rsp_valid in reset", 64'(rsp_valid_o), 64'd0);
                    check("busy in reset", 64'(busy_o), 64'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    v = 0;
                    repeat (10) begin
                        @(negedge clk);
                        #1;
                        if (rsp_valid_o) v++;
                    end
                    check("no nibbles after reset", 64'(v), 64'd0);
                    check("ready after reset", 64'(req_ready_o), 64'd1);
                    err_exp = 1'b0;
                    return;
                end
            end
        end
        check("read nibbles received", 64'(got), 64'd8);
        if (got != 8) return;
        @(negedge clk);
        rsp_ready_i = 1'($urandom);
        #1;
        check("commit valid", 64'(rsp_valid_o), 64'd1);
        check("commit nibble", 64'(rsp_nibble_o), 64'd0);
        check("commit last", 64'(rsp_last_o), 64'd0);
        @(negedge clk);
        #1;
        check("valid after commit", 64'(rsp_valid_o), 64'd0);
        check("busy after read", 64'(busy_o), 64'd0);
        check("read access count", 64'(acc_wr - start), 64'd1);
        if (acc_wr > start) begin
            r = acc_log[start];
            check("read we", 64'(r.we), 64'd0);
            check("read addr", 64'(r.addr), 64'(a));
            check("read be", 64'(r.be), 64'hF);
        end
    endtask

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] data;       // write: beat k nibble at [4k+3:4k]; read: memory word
        logic [7:0]  strb;
        int          gnt_delay;
        int          ready_mode; // 0 always ready, 1 toggling, 2 random
        logic [3:0]  exp_be;
        logic        exp_err;
        logic [31:0] exp_seq;    // write: mem_wdata; read: nibble k at [4k+3:4k]
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          m0;
        int          a0;
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [7:0]  rs;
        int          rgd;

        for (int i = 0; i < 256; i++) rmem[i] = $urandom;

        vecs[0] = '{1'b1, 8'h12, 32'h17C30FA5, 8'hFF, 0, 0, 4'hF,    1'b0, 32'h17C30FA5};
        vecs[1] = '{1'b1, 8'h20, 32'h89ABCDEF, 8'h33, 2, 0, 4'b0101, 1'b0, 32'h89ABCDEF};
        vecs[2] = '{1'b0, 8'h34, 32'hDEADBEEF, 8'h00, 0, 0, 4'hF,    1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 8'h34, 32'hDEADBEEF, 8'h00, 3, 1, 4'hF,    1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 8'h40, 32'h01234567, 8'hFD, 1, 0, 4'hF,    1'b1, 32'h01234567};
        vecs[5] = '{1'b1, 8'h41, 32'hCAFEF00D, 8'h0F, 0, 0, 4'b0011, 1'b1, 32'hCAFEF00D};

        #3;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset mem_req", 64'(mem_req_o), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset rsp_nibble", 64'(rsp_nibble_o), 64'd0);
        check("reset rsp_last", 64'(rsp_last_o), 64'd0);
        check("reset err_strb", 64'(err_strb_o), 64'd0);
        check("reset mem_wdata", 64'(mem_wdata_o), 64'd0);
        check("reset mem_addr", 64'(mem_addr_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready after first clock", 64'(req_ready_o), 64'd1);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].write) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].gnt_delay, 1'b0, 0,
                         vecs[v].exp_be, vecs[v].exp_seq, vecs[v].exp_err);
            end else begin
                rmem[vecs[v].addr] = vecs[v].data;
                do_read(vecs[v].addr, vecs[v].gnt_delay, vecs[v].ready_mode, vecs[v].exp_seq, 99);
                check("err_strb after read", 64'(err_strb_o), 64'(vecs[v].exp_err));
            end
            err_exp = vecs[v].exp_err;
        end

        // Reset after four write beats: transaction dropped, sticky error cleared.
        gnt_delay = 0;
        for (int k = 0; k < 4; k++) send_beat(4'(k + 1), 1'b1, 1'b1, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-write reset busy", 64'(busy_o), 64'd0);
        check("mid-write reset mem_req", 64'(mem_req_o), 64'd0);
        check("mid-write reset err_strb", 64'(err_strb_o), 64'd0);
        check("mid-write reset wdata", 64'(mem_wdata_o), 64'd0);
        m0 = mreq_cnt;
        a0 = acc_wr;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("no mem_req after reset", 64'(mreq_cnt - m0), 64'd0);
        check("no access after reset", 64'(acc_wr - a0), 64'd0);
        check("ready after mid-write reset", 64'(req_ready_o), 64'd1);
        err_exp = 1'b0;
        do_read(8'h66, 0, 0, rmem[8'h66], 99);

        // Reset after three response nibbles, then a normal read.
        do_read(8'h55, 1, 0, rmem[8'h55], 3);
        do_read(8'h56, 0, 2, rmem[8'h56], 99);
        check("err_strb after resets", 64'(err_strb_o), 64'd0);

        for (int t = 0; t < 30; t++) begin
            ra  = 8'($urandom);
            rd  = $urandom;
            rgd = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                rs = 8'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < 4; i++) rs[2*i+1] = rs[2*i];
                end
                err_exp = err_exp | model_mis(rs);
                do_write(ra, rd, rs, rgd, 1'b1, 2, model_be(rs), rd, err_exp);
            end else begin
                rmem[ra] = rd;
                do_read(ra, rgd, int'($urandom_range(0, 2)), rd, 99);
                check("err_strb after random read", 64'(err_strb_o), 64'(err_exp));
            end
        end

        check("mem request held until grant", 64'(hold_errs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
